// File: rtl/dbus_dma_pkg.sv
// Shared definitions for the dbus DMA initiator: bus handshake structs,
// FSM state type, word size and an address-step helper.
package dbus_dma_pkg;

    // Master -> peripheral request bundle
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] w_data;
        logic        w_en;
        logic        req;
    } type_dbus2peri_s;

    // Peripheral -> master response bundle
    typedef struct packed {
        logic [31:0] r_data;
        logic        ack;
    } type_peri2dbus_s;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } type_dma_state_e;

    localparam int unsigned DMA_WORD_BYTES = 4;

    // Next address for one beat; wraps modulo 2^32, low bits pass through
    function automatic logic [31:0] addr_step(input logic [31:0] addr, input logic inc);
        return inc ? (addr + 32'(DMA_WORD_BYTES)) : addr;
    endfunction

endpackage

// File: rtl/dbus_dma_addr_gen.sv
// Source/destination address registers for the DMA. Both channels share
// one structure: load base and increment mode on start, step on advance.
module dbus_dma_addr_gen
    import dbus_dma_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        adv,
    input  logic [31:0] cfg_src,
    input  logic [31:0] cfg_dst,
    input  logic        cfg_sinc,
    input  logic        cfg_dinc,
    output logic [31:0] src_addr,
    output logic [31:0] dst_addr
);

    // Channel 0 is the source, channel 1 the destination
    logic [1:0][31:0] cfg_addr;
    logic [1:0]       cfg_inc;
    logic [1:0][31:0] addr_all;

    assign cfg_addr = {cfg_dst, cfg_src};
    assign cfg_inc  = {cfg_dinc, cfg_sinc};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic [31:0] addr_reg;
            logic        inc_reg;

            // Load base on start, then step by one word per completed beat
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    addr_reg <= '0;
                    inc_reg  <= 1'b0;
                end else if (load) begin
                    addr_reg <= cfg_addr[gi];
                    inc_reg  <= cfg_inc[gi];
                end else if (adv) begin
                    addr_reg <= addr_step(addr_reg, inc_reg);
                end
            end

            assign addr_all[gi] = addr_reg;
        end
    endgenerate

    assign src_addr = addr_all[0];
    assign dst_addr = addr_all[1];

endmodule

// File: rtl/dbus_dma.sv
// dbus DMA initiator: copies cfg_len_i words from source to destination
// with alternating read and write beats on the dbus handshake.
// Optional feature: define DBUS_DMA_TIMEOUT_EN to abandon a request that
// has not been acknowledged within TOUT_CYC cycles.
module dbus_dma
    import dbus_dma_pkg::*;
#(
    parameter int LEN_W = 16
`ifdef DBUS_DMA_TIMEOUT_EN
    , parameter int TOUT_CYC = 64
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [31:0]      cfg_src_i,
    input  logic [31:0]      cfg_dst_i,
    input  logic [LEN_W-1:0] cfg_len_i,
    input  logic             cfg_sinc_i,
    input  logic             cfg_dinc_i,
    output type_dbus2peri_s  dma2dbus_o,
    input  type_peri2dbus_s  dbus2dma_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    type_dma_state_e state_reg, state_next;
    type_dbus2peri_s bus_reg, bus_next;
    logic [31:0]      buf_reg, buf_next;
    logic [LEN_W-1:0] cnt_reg, cnt_next;
    logic             abort_reg, abort_next;
    logic             err_reg, err_next;
    logic             abort_pend;
    logic             addr_load;
    logic             addr_adv;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;

`ifdef DBUS_DMA_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TOUT_CYC + 1);
    logic [WAIT_W-1:0] wait_reg, wait_next;
`endif

    dbus_dma_addr_gen u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (addr_load),
        .adv      (addr_adv),
        .cfg_src  (cfg_src_i),
        .cfg_dst  (cfg_dst_i),
        .cfg_sinc (cfg_sinc_i),
        .cfg_dinc (cfg_dinc_i),
        .src_addr (src_addr),
        .dst_addr (dst_addr)
    );

    // State and datapath registers; reset drops req immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            bus_reg   <= '0;
            buf_reg   <= '0;
            cnt_reg   <= '0;
            abort_reg <= 1'b0;
            err_reg   <= 1'b0;
`ifdef DBUS_DMA_TIMEOUT_EN
            wait_reg  <= '0;
`endif
        end else begin
            state_reg <= state_next;
            bus_reg   <= bus_next;
            buf_reg   <= buf_next;
            cnt_reg   <= cnt_next;
            abort_reg <= abort_next;
            err_reg   <= err_next;
`ifdef DBUS_DMA_TIMEOUT_EN
            wait_reg  <= wait_next;
`endif
        end
    end

    // Next-state logic. A request is raised on the cycle after the previous
    // ack was sampled (req low for one dead cycle), held until ack, then
    // dropped on the edge that samples ack.
    always_comb begin
        state_next = state_reg;
        bus_next   = bus_reg;
        buf_next   = buf_reg;
        cnt_next   = cnt_reg;
        abort_next = abort_reg;
        err_next   = err_reg;
        addr_load  = 1'b0;
        addr_adv   = 1'b0;
        abort_pend = abort_reg | abort_i;
`ifdef DBUS_DMA_TIMEOUT_EN
        wait_next  = wait_reg;
`endif

        case (state_reg)
            IDLE: begin
                // Abort is ignored here; a start in the same cycle wins
                if (start_i) begin
                    err_next   = 1'b0;
                    abort_next = 1'b0;
                    if (cfg_len_i != '0) begin
                        addr_load     = 1'b1;
                        cnt_next      = cfg_len_i;
                        bus_next      = '0;
                        bus_next.req  = 1'b1;
                        bus_next.addr = cfg_src_i;
`ifdef DBUS_DMA_TIMEOUT_EN
                        wait_next     = '0;
`endif
                        state_next    = RD;
                    end else begin
                        state_next = DONE;
                    end
                end
            end

            RD: begin
                abort_next = abort_pend;
                if (!bus_reg.req) begin
                    bus_next      = '0;
                    bus_next.req  = 1'b1;
                    bus_next.addr = src_addr;
`ifdef DBUS_DMA_TIMEOUT_EN
                    wait_next     = '0;
`endif
                end else if (dbus2dma_i.ack) begin
                    // Read data is always written back, even if abort is pending
                    buf_next   = dbus2dma_i.r_data;
                    bus_next   = '0;
                    state_next = WR;
                end
`ifdef DBUS_DMA_TIMEOUT_EN
                else if (wait_reg == WAIT_W'(TOUT_CYC - 1)) begin
                    bus_next   = '0;
                    err_next   = 1'b1;
                    state_next = DONE;
                end else begin
                    wait_next = wait_reg + 1'b1;
                end
`endif
            end

            WR: begin
                abort_next = abort_pend;
                if (!bus_reg.req) begin
                    bus_next        = '0;
                    bus_next.req    = 1'b1;
                    bus_next.w_en   = 1'b1;
                    bus_next.addr   = dst_addr;
                    bus_next.w_data = buf_reg;
`ifdef DBUS_DMA_TIMEOUT_EN
                    wait_next       = '0;
`endif
                end else if (dbus2dma_i.ack) begin
                    bus_next = '0;
                    addr_adv = 1'b1;
                    if (cnt_reg != '0) begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                    if ((cnt_reg <= LEN_W'(1)) || abort_pend) begin
                        err_next   = err_reg | abort_pend;
                        state_next = DONE;
                    end else begin
                        state_next = RD;
                    end
                end
`ifdef DBUS_DMA_TIMEOUT_EN
                else if (wait_reg == WAIT_W'(TOUT_CYC - 1)) begin
                    // cnt_reg is kept so software can see the words left
                    bus_next   = '0;
                    err_next   = 1'b1;
                    state_next = DONE;
                end else begin
                    wait_next = wait_reg + 1'b1;
                end
`endif
            end

            DONE: begin
                abort_next = 1'b0;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign dma2dbus_o = bus_reg;
    assign busy_o     = (state_reg != IDLE);
    assign done_o     = (state_reg == DONE);
    assign err_o      = err_reg;

endmodule

// File: tb/tb_dbus_dma.sv
// Randomized scoreboard bench for dbus_dma: the stimulus side predicts every
// bus beat and completion from the transfer parameters; a monitor pops and
// compares whenever a beat is acknowledged or done_o pulses.
module tb_dbus_dma;
    import dbus_dma_pkg::*;

    localparam int          LIMIT     = 5000;
    localparam logic [31:0] GPSW_DATA = 32'hF000_0010;

    typedef struct packed {
        logic [31:0] addr;
        logic        w_en;
        logic [31:0] data;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start_i, abort_i;
    logic [31:0]     cfg_src_i, cfg_dst_i;
    logic [15:0]     cfg_len_i;
    logic            cfg_sinc_i, cfg_dinc_i;
    type_dbus2peri_s bus;
    type_peri2dbus_s rsp;
    logic            busy_o, done_o, err_o;

    logic        ack_r;
    logic [31:0] rdata_r;
    int          stall_cnt, stall_tgt, wr_acc;
    int          lat_max = 0;
    bit          no_ack  = 1'b0;

    beat_t exp_q[$];
    bit    done_q[$];
    beat_t mon_e;
    bit    mon_d;
    int    n_checks = 0;
    int    n_pass   = 0;

    always #5 clk = ~clk;

    assign rsp.r_data = rdata_r;
    assign rsp.ack    = ack_r;

    dbus_dma #(.LEN_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .abort_i    (abort_i),
        .cfg_src_i  (cfg_src_i),
        .cfg_dst_i  (cfg_dst_i),
        .cfg_len_i  (cfg_len_i),
        .cfg_sinc_i (cfg_sinc_i),
        .cfg_dinc_i (cfg_dinc_i),
        .dma2dbus_o (bus),
        .dbus2dma_i (rsp),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    // Contents of the memory/peripheral space as seen by reads
    function automatic logic [31:0] init_val(input logic [31:0] a);
        if (a == GPSW_DATA) return 32'h0000_A5A5;
        return {a[15:0], ~a[31:16]} ^ 32'h3C3C_1F1F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endtask

    // Responder: acks after a random stall, ignores req while its ack is high
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_r     <= 1'b0;
            rdata_r   <= '0;
            stall_cnt <= 0;
            wr_acc    <= 0;
        end else if (ack_r) begin
            ack_r <= 1'b0;
        end else if (bus.req && !no_ack) begin
            if (stall_cnt < stall_tgt) begin
                stall_cnt <= stall_cnt + 1;
            end else begin
                ack_r     <= 1'b1;
                stall_cnt <= 0;
                stall_tgt <= int'($urandom_range(0, lat_max));
                rdata_r   <= bus.w_en ? 32'h0 : init_val(bus.addr);
                if (bus.w_en) wr_acc <= wr_acc + 1;
            end
        end
    end

    // Monitor: one line per acknowledged beat or completion pulse
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.req && ack_r) begin
                check("beat_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    $display("beat %s addr=0x%08h data=0x%08h",
                             bus.w_en ? "WR" : "RD", bus.addr, bus.w_en ? bus.w_data : rdata_r);
                    check("beat_addr", bus.addr, mon_e.addr);
                    check("beat_w_en", bus.w_en, mon_e.w_en);
                    if (mon_e.w_en) check("beat_w_data", bus.w_data, mon_e.data);
                end
            end
            if (done_o) begin
                check("done_expected", done_q.size() != 0, 1'b1);
                if (done_q.size() != 0) begin
                    mon_d = done_q.pop_front();
                    $display("done err=%0b", err_o);
                    check("done_err", err_o, mon_d);
                end
            end
        end
    end

    task automatic pulse_start(input logic [31:0] src, input logic [31:0] dst, input int len,
                               input bit sinc, input bit dinc, input bit abort_too);
        cfg_src_i  = src;
        cfg_dst_i  = dst;
        cfg_len_i  = 16'(len);
        cfg_sinc_i = sinc;
        cfg_dinc_i = dinc;
        start_i    = 1'b1;
        abort_i    = abort_too;
        @(negedge clk);
        start_i    = 1'b0;
        abort_i    = 1'b0;
    endtask

    task automatic push_expect(input logic [31:0] src, input logic [31:0] dst, input int nwords,
                               input bit sinc, input bit dinc);
        beat_t       b;
        logic [31:0] ra, wa;
        for (int k = 0; k < nwords; k++) begin
            ra = src + (sinc ? 32'(4 * k) : 32'd0);
            wa = dst + (dinc ? 32'(4 * k) : 32'd0);
            b.addr = ra; b.w_en = 1'b0; b.data = 32'h0;
            exp_q.push_back(b);
            b.addr = wa; b.w_en = 1'b1; b.data = init_val(ra);
            exp_q.push_back(b);
        end
    endtask

    task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input int len,
                            input bit sinc, input bit dinc, input int abort_at,
                            input bit extra_start, input bit abort_with_start);
        int cyc;
        int base;
        push_expect(src, dst, (abort_at >= 0) ? abort_at + 1 : len, sinc, dinc);
        done_q.push_back(abort_at >= 0);
        base = wr_acc;
        pulse_start(src, dst, len, sinc, dinc, abort_with_start);
        if (abort_at >= 0) begin
            for (cyc = 0; cyc < LIMIT; cyc++) begin
                if (bus.req && !bus.w_en && (wr_acc - base) == abort_at) break;
                @(negedge clk);
            end
            check("abort_window_found", cyc < LIMIT, 1'b1);
            abort_i = 1'b1;
            @(negedge clk);
            abort_i = 1'b0;
        end else if (extra_start && len >= 2) begin
            // A start while busy must be ignored
            repeat (3) @(negedge clk);
            pulse_start(32'h7777_0000, 32'h8888_0000, 0, 1'b0, 1'b0, 1'b0);
        end
        for (cyc = 0; cyc < LIMIT; cyc++) begin
            if (done_o) break;
            @(negedge clk);
        end
        check("done_seen", cyc < LIMIT, 1'b1);
        if (len == 0) check("zero_len_done_latency", cyc, 0);
        @(negedge clk);
        check("beats_left", exp_q.size(), 0);
        check("busy_after_done", busy_o, 1'b0);
        check("err_sticky", err_o, abort_at >= 0);
    endtask

    initial begin
        int          len_r, ab_r, cyc;
        bit          si_r, di_r;
        logic [31:0] s_r, d_r;

        rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0;
        cfg_src_i = '0; cfg_dst_i = '0; cfg_len_i = '0; cfg_sinc_i = 1'b0; cfg_dinc_i = 1'b0;
        stall_tgt = 0;
        repeat (3) @(negedge clk);
        check("reset_req", bus.req, 1'b0);
        check("reset_bus", bus, '0);
        check("reset_busy", busy_o, 1'b0);
        check("reset_done", done_o, 1'b0);
        check("reset_err", err_o, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic copy, fixed-source peripheral read, zero length, abort
        lat_max = 0;
        run_xfer(32'h0000_0100, 32'h0000_0200, 3, 1'b1, 1'b1, -1, 1'b0, 1'b0);
        run_xfer(GPSW_DATA, 32'h0000_0300, 2, 1'b0, 1'b1, -1, 1'b0, 1'b0);
        run_xfer(32'h0000_0400, 32'h0000_0500, 0, 1'b1, 1'b1, -1, 1'b0, 1'b0);
        run_xfer(32'h0000_0600, 32'h0000_0700, 8, 1'b1, 1'b1, 1, 1'b0, 1'b0);
        // err cleared by the next accepted start; abort beside start is ignored
        run_xfer(32'h0000_0800, 32'h0000_0900, 2, 1'b1, 1'b0, -1, 1'b0, 1'b1);

        // Randomized transfers including address wrap and unaligned addresses
        for (int t = 0; t < 14; t++) begin
            len_r = int'($urandom_range(1, 12));
            s_r   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0
                                                : (32'h1000_0000 | ($urandom & 32'h0000_FFFC));
            s_r   = s_r | 32'($urandom_range(0, 3));
            d_r   = 32'h2000_0000 | ($urandom & 32'h0000_FFFF);
            si_r  = 1'($urandom_range(0, 1));
            di_r  = 1'($urandom_range(0, 1));
            lat_max = int'($urandom_range(0, 3));
            ab_r  = (len_r >= 2 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, len_r - 2)) : -1;
            run_xfer(s_r, d_r, len_r, si_r, di_r, ab_r, 1'($urandom_range(0, 1)),
                     (ab_r < 0) && ($urandom_range(0, 3) == 0));
        end

        // Reset during a write with req high, then restart
        lat_max = 1;
        push_expect(32'h0000_1000, 32'h0000_2000, 4, 1'b1, 1'b1);
        done_q.push_back(1'b0);
        pulse_start(32'h0000_1000, 32'h0000_2000, 4, 1'b1, 1'b1, 1'b0);
        for (cyc = 0; cyc < LIMIT; cyc++) begin
            if (bus.req && bus.w_en) break;
            @(negedge clk);
        end
        check("wr_req_found", cyc < LIMIT, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_req", bus.req, 1'b0);
        check("async_reset_busy", busy_o, 1'b0);
        exp_q.delete();
        done_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_done", done_o, 1'b0);
        run_xfer(32'h0000_3000, 32'h0000_4000, 3, 1'b1, 1'b1, -1, 1'b0, 1'b0);

        // Responder that never acks
        no_ack = 1'b1;
`ifdef DBUS_DMA_TIMEOUT_EN
        done_q.push_back(1'b1);
        pulse_start(32'h0000_5000, 32'h0000_6000, 2, 1'b1, 1'b1, 1'b0);
        for (cyc = 0; cyc < 300; cyc++) begin
            if (!bus.req) break;
            @(negedge clk);
        end
        check("timeout_req_cycles", cyc, 64);
        check("timeout_done", done_o, 1'b1);
        @(negedge clk);
        check("timeout_err", err_o, 1'b1);
        check("timeout_idle", busy_o, 1'b0);
        no_ack = 1'b0;
`else
        pulse_start(32'h0000_5000, 32'h0000_6000, 2, 1'b1, 1'b1, 1'b0);
        repeat (150) @(negedge clk);
        check("no_timeout_req_held", bus.req, 1'b1);
        check("no_timeout_busy", busy_o, 1'b1);
        check("no_timeout_err", err_o, 1'b0);
        rst_n = 1'b0;
        no_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`endif
        check("final_queue_empty", done_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
